// File: rtl/iterative_divider_pkg.sv
// Shared definitions for the iterative divider.
// div_op_e : operation select, encoded as the RV32M/RV64M funct3[1:0] of DIV/DIVU/REM/REMU.
// state_e  : control FSM states.
package iterative_divider_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    PREP   = 2'b01,
    ITER   = 2'b10,
    FINISH = 2'b11
  } state_e;

  function automatic logic op_is_signed(div_op_e op);
    return (op == DIV) || (op == REM);
  endfunction

  function automatic logic op_is_rem(div_op_e op);
    return (op == REM) || (op == REMU);
  endfunction

endpackage

// File: rtl/dff_re.sv
// Resettable flop with load enable.
// clk  : clock
// rst  : asynchronous active-high reset, clears q_o to zero
// en_i : load enable
// d_i  : next value
// q_o  : registered value
module dff_re #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_o <= '0;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/div_step.sv
// One restoring shift-subtract step of an unsigned divider (purely combinational).
// rem_i     : partial remainder, always < divisor_i
// quo_i     : dividend bits still to shift out (MSB first) / quotient bits shifted in
// divisor_i : divisor magnitude
// rem_o     : next partial remainder
// quo_o     : next dividend/quotient register
// q_bit_o   : quotient bit produced by this step
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] diff;

  // The shifted remainder is < 2*divisor, so a non-negative difference always
  // fits in WIDTH bits and diff[WIDTH] is purely the borrow.
  assign diff    = {rem_i, quo_i[WIDTH-1]} - {1'b0, divisor_i};
  assign q_bit_o = ~diff[WIDTH];
  assign rem_o   = q_bit_o ? diff[WIDTH-1:0] : {rem_i[WIDTH-2:0], quo_i[WIDTH-1]};
  assign quo_o   = {quo_i[WIDTH-2:0], q_bit_o};

endmodule

// File: rtl/iterative_divider.sv
// Multi-cycle RV32M/RV64M divider: DIV, DIVU, REM, REMU.
// clk    : clock
// reset  : asynchronous active-high reset
// Start  : request a new operation (sampled only in IDLE)
// DivOp  : operation select (div_op_e encoding)
// Rs1    : dividend
// Rs2    : divisor
// Flush  : abort any operation in flight
// Busy   : high whenever the FSM is not IDLE
// Done   : one-cycle pulse while Result holds a new value
// Result : quotient or remainder, registered and held until the next completion
module iterative_divider
  import iterative_divider_pkg::*;
#(
  parameter int BIT_COUNT = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 Start,
  input  logic [1:0]           DivOp,
  input  logic [BIT_COUNT-1:0] Rs1,
  input  logic [BIT_COUNT-1:0] Rs2,
  input  logic                 Flush,
  output logic                 Busy,
  output logic                 Done,
  output logic [BIT_COUNT-1:0] Result
);

  localparam int CW = $clog2(BIT_COUNT) + 1;

  logic [1:0]           state_raw, op_raw;
  state_e               state_q, state_d;
  div_op_e              op_q;
  logic [BIT_COUNT-1:0] rs1_q, rs2_q;
  logic [CW-1:0]        counter_q, counter_d;
  logic                 accept;

  logic [BIT_COUNT-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [BIT_COUNT-1:0] result_q, result_d;
  logic                 neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;

  logic [BIT_COUNT-1:0] step_rem, step_quo;
  logic                 step_qbit;

  assign state_q = state_e'(state_raw);
  assign op_q    = div_op_e'(op_raw);

  dff_re #(.WIDTH(2)) u_state_ff (
    .clk(clk), .rst(reset), .en_i(1'b1), .d_i(state_d), .q_o(state_raw)
  );
  dff_re #(.WIDTH(2)) u_op_ff (
    .clk(clk), .rst(reset), .en_i(accept), .d_i(DivOp), .q_o(op_raw)
  );
  dff_re #(.WIDTH(BIT_COUNT)) u_rs1_ff (
    .clk(clk), .rst(reset), .en_i(accept), .d_i(Rs1), .q_o(rs1_q)
  );
  dff_re #(.WIDTH(BIT_COUNT)) u_rs2_ff (
    .clk(clk), .rst(reset), .en_i(accept), .d_i(Rs2), .q_o(rs2_q)
  );
  dff_re #(.WIDTH(CW)) u_counter_ff (
    .clk(clk), .rst(reset), .en_i(1'b1), .d_i(counter_d), .q_o(counter_q)
  );

  div_step #(.WIDTH(BIT_COUNT)) u_div_step (
    .rem_i(rem_q), .quo_i(quo_q), .divisor_i(dvs_q),
    .rem_o(step_rem), .quo_o(step_quo), .q_bit_o(step_qbit)
  );

  // Operand preparation, evaluated from the latched operands during PREP.
  logic                 is_signed, is_rem, sign1, sign2, div_by_zero, overflow;
  logic [BIT_COUNT-1:0] abs1, abs2, special_res, final_res;

  assign is_signed   = op_is_signed(op_q);
  assign is_rem      = op_is_rem(op_q);
  assign sign1       = is_signed & rs1_q[BIT_COUNT-1];
  assign sign2       = is_signed & rs2_q[BIT_COUNT-1];
  assign abs1        = sign1 ? -rs1_q : rs1_q;
  assign abs2        = sign2 ? -rs2_q : rs2_q;
  assign div_by_zero = (rs2_q == '0);
  // Most-negative / -1 overflows the signed quotient; RISC-V defines the result.
  assign overflow    = is_signed && (rs1_q == {1'b1, {(BIT_COUNT-1){1'b0}}}) && (rs2_q == '1);
  assign special_res = div_by_zero ? (is_rem ? rs1_q : '1)
                                   : (is_rem ? '0    : rs1_q);
  assign final_res   = is_rem ? (neg_rem_q ? -step_rem : step_rem)
                              : (neg_quo_q ? -step_quo : step_quo);

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d   = state_q;
    counter_d = counter_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    accept    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (Start && !Flush) begin
          accept  = 1'b1;
          state_d = PREP;
        end
      end
      PREP: begin
        neg_quo_d = sign1 ^ sign2;
        neg_rem_d = sign1;
        rem_d     = '0;
        quo_d     = abs1;
        dvs_d     = abs2;
        counter_d = CW'(BIT_COUNT);
        if (div_by_zero || overflow) begin
          result_d = special_res;
          state_d  = FINISH;
        end else begin
          state_d  = ITER;
        end
      end
      ITER: begin
        rem_d     = step_rem;
        quo_d     = step_quo;
        counter_d = counter_q - CW'(1);
        if (counter_q == CW'(1)) begin
          result_d = final_res;
          state_d  = FINISH;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A squash aborts whatever is in flight and must not commit a result.
    // In FINISH the result was already committed on entry, so it stays.
    if (Flush) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  // The new quotient bit must be the LSB of the shifted quotient register.
  always_comb begin
    if (state_q == ITER) begin
      assert (step_quo[0] == step_qbit);
    end
  end

  // NOTE: datapath registers are reset too, so the first operation never sees X.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

  assign Busy   = (state_q != IDLE);
  assign Done   = (state_q == FINISH);
  assign Result = result_q;

endmodule
